target_io_router: RTL and testbench
===================================

// Module: target_io_router
// PURPOSE
//  Parametrised successor to the hard-wired target-pin muxing in the board top level. It routes
//  CHANNELS target IO pins between hi-Z, register GPIO, open-drain GPIO and two alternate
//  functions (e.g. UART, AVR-prog SPI). It adds a target-power sequencer with a settle delay and
//  per-channel break-before-make blanking on mode change. Sits on the reg_* bus beside the other
//  register blocks. The top level builds the tristates from io_out/io_oe.
// PARAMETERS
//  CHANNELS    8     number of target IO channels (1..16)
//  BBM_CYCLES  2     cycles io_oe is forced low after a channel mode change (>=1)
//  ADDR_MODE   6'd40 mode registers, one byte per channel, byte index = channel
//  ADDR_GPIO   6'd41 GPIO output values, bit n = channel n, ceil(CHANNELS/8) bytes
//  ADDR_PWR    6'd42 byte0: bit0 pwr_en; bytes1-2: settle count (16b, little-endian)
//  ADDR_STATUS 6'd43 read-only: bytes0..: synced io_in; last byte: bits[1:0] pwr state
// PORTS
//  clk             in   1   system/register clock
//  reset_n         in   1   asynchronous, active-low reset
//  reg_address     in   6   register address
//  reg_bytecnt     in   16  byte index within register
//  reg_datai       in   8   write data
//  reg_datao       out  8   read data; 0 when not addressed (OR-combined bus)
//  reg_read        in   1   read strobe
//  reg_write       in   1   write strobe
//  reg_addrvalid   in   1   address valid
//  reg_hypaddress  in   6   address for length query
//  reg_hyplen      out  16  register length; 0 for addresses not owned
//  alt_a_i         in   CHANNELS  alternate function A output value per channel
//  alt_b_i         in   CHANNELS  alternate function B output value per channel
//  io_in           in   CHANNELS  raw pad input values (asynchronous)
//  io_in_sync      out  CHANNELS  2-flop synchronised pad inputs
//  io_out          out  CHANNELS  pad output value
//  io_oe           out  CHANNELS  pad output enable (1 = drive)
//  target_npower   out  1   target power switch, active-low
// BEHAVIOUR
//  - Reset: modes=0 (HIZ), gpio=0, pwr_en=0, settle=16'd1000, state OFF. io_oe=0, io_out=0,
//    target_npower=1, io_in_sync=0, reg_datao=0. Reset mid-operation drops power immediately.
//  - Write: a cycle with reg_write&reg_addrvalid updates the addressed byte at that edge.
//    Bytes beyond the register length are ignored.
//  - Read: reg_datao is combinational from reg_address/reg_bytecnt when reg_addrvalid&reg_read, else 0.
//  - reg_hyplen: MODE=CHANNELS, GPIO=ceil(CHANNELS/8), PWR=3, STATUS=ceil(CHANNELS/8)+1, other=0.
//  - Mode field bits[2:0]: 0 HIZ(oe=0); 1 GPIO(oe=1,out=gpio); 2 OD(out=0,oe=~gpio); 3 ALT_A
//    (oe=1,out=alt_a); 4 ALT_B(oe=1,out=alt_b); 5-7 treated as HIZ. Bits[7:3] read back as 0.
//  - io_out/io_oe are registered: 1 cycle latency from register or alt input change to pad.
//  - Power FSM OFF->SETTLE->ON:
//    OFF: npower=1, all oe=0. Goes to SETTLE when pwr_en=1; counter loads settle.
//    SETTLE: npower=0, all oe=0, counter decrements. Goes to ON when it reaches 0.
//      With settle=0, ON is reached the cycle after entry.
//    ON: oe per mode.
//    pwr_en=0 in any state -> OFF on the next edge. A settle write during SETTLE does not affect
//    the running count.
//  - Break-before-make: a MODE byte write with a value different from the current one loads that
//    channel's blank counter with BBM_CYCLES. While the counter is nonzero that channel's oe=0.
//    A same-value write does not blank. A write during blanking reloads the counter.
//  - io_in_sync: 2-flop synchroniser, 2-cycle latency, also readable via STATUS.
//  - STATUS last byte bits[1:0]: 0 OFF, 1 SETTLE, 2 ON.
// STRUCTURE
//  - Shared package/includes: mode encodings (TIO_HIZ..TIO_ALTB), power state encodings, ADDR_*
//    defaults.
//  - One sub-module, tio_channel: per-channel mode register, blank counter and output mux,
//    instantiated CHANNELS times via generate.
//  - The power FSM and the register decode live in the top of this block.
// TESTING
//  1. Reset, CHANNELS=8: read STATUS last byte -> 0x00; io_oe=0x00, target_npower=1, hyplen(40)=8.
//  2. Write PWR settle=5 then pwr_en=1 -> npower=0 next edge; oe stays 0 for 5 cycles, then state
//     reads 2.
//  3. In ON, MODE[3]=1, GPIO=0x08 -> io_oe[3]=0 for 2 cycles, then io_oe[3]=1, io_out[3]=1.
//     Rewriting 1 causes no blank.
//  4. MODE[0]=2 (OD), GPIO bit0 0->1 -> io_out[0]=0 with io_oe[0] 1->0. MODE[1]=3 -> io_out[1]
//     follows alt_a_i[1] with 1-cycle lag.
//  5. Clear pwr_en while in SETTLE with 3 cycles left -> OFF next edge, npower=1, all oe=0,
//     ON never reached.
//  6. Toggle io_in[5] -> io_in_sync[5] follows after 2 cycles. Read addr 6'd20 -> reg_datao=0,
//     reg_hyplen=0.

Source files
------------

// File: rtl/target_io_router_pkg.sv
// Shared encodings for the target IO router: per-channel pin modes, target power
// sequencer states and default register addresses.
package target_io_router_pkg;

  typedef enum logic [2:0] {
    TIO_HIZ  = 3'd0,
    TIO_GPIO = 3'd1,
    TIO_OD   = 3'd2,
    TIO_ALTA = 3'd3,
    TIO_ALTB = 3'd4
  } tio_mode_e;

  typedef enum logic [1:0] {
    TIO_PWR_OFF    = 2'd0,
    TIO_PWR_SETTLE = 2'd1,
    TIO_PWR_ON     = 2'd2
  } tio_pwr_e;

  localparam logic [5:0]  TIO_ADDR_MODE    = 6'd40;
  localparam logic [5:0]  TIO_ADDR_GPIO    = 6'd41;
  localparam logic [5:0]  TIO_ADDR_PWR     = 6'd42;
  localparam logic [5:0]  TIO_ADDR_STATUS  = 6'd43;
  localparam logic [15:0] TIO_SETTLE_RESET = 16'd1000;

  // Bytes needed to hold one bit per channel.
  function automatic int tio_bytes(input int bits);
    return (bits + 7) / 8;
  endfunction

endpackage

// File: rtl/target_io_router_channel.sv
// One target IO channel: mode register, break-before-make blank counter and the
// registered output/enable mux that feeds the pad tristate.
module tio_channel
  import target_io_router_pkg::*;
#(
  parameter int BBM_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       mode_we_i,
  input  logic [2:0] mode_wdata_i,
  input  logic       gpio_i,
  input  logic       alt_a_i,
  input  logic       alt_b_i,
  input  logic       pwr_on_i,
  output logic [2:0] mode_o,
  output logic       io_out_o,
  output logic       io_oe_o
);

  localparam int BW = $clog2(BBM_CYCLES + 1);

  logic [2:0]    mode_q, mode_d;
  logic [BW-1:0] blank_q, blank_d;
  logic          out_q, out_d;
  logic          oe_q, oe_d;
  logic          mode_oe;

  always_comb begin
    mode_d  = mode_q;
    blank_d = blank_q;
    if (blank_q != '0) blank_d = blank_q - BW'(1);
    if (mode_we_i) begin
      mode_d = mode_wdata_i;
      // Only a real change of mode blanks; rewriting the same mode keeps driving.
      if (mode_wdata_i != mode_q) blank_d = BW'(BBM_CYCLES);
    end
  end

  always_comb begin
    out_d   = 1'b0;
    mode_oe = 1'b0;
    case (mode_q)
      TIO_GPIO: begin out_d = gpio_i;  mode_oe = 1'b1;    end
      TIO_OD:   begin out_d = 1'b0;    mode_oe = ~gpio_i; end
      TIO_ALTA: begin out_d = alt_a_i; mode_oe = 1'b1;    end
      TIO_ALTB: begin out_d = alt_b_i; mode_oe = 1'b1;    end
      default:  begin out_d = 1'b0;    mode_oe = 1'b0;    end
    endcase
    oe_d = mode_oe & pwr_on_i & (blank_q == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q  <= 3'd0;
      blank_q <= '0;
      out_q   <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      blank_q <= blank_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
    end
  end

  assign mode_o   = mode_q;
  assign io_out_o = out_q;
  assign io_oe_o  = oe_q;

endmodule

// File: rtl/target_io_router.sv
// Target IO pin router: register decode, target power sequencer and input
// synchroniser around CHANNELS tio_channel instances.
module target_io_router
  import target_io_router_pkg::*;
#(
  parameter int         CHANNELS    = 8,
  parameter int         BBM_CYCLES  = 2,
  parameter logic [5:0] ADDR_MODE   = TIO_ADDR_MODE,
  parameter logic [5:0] ADDR_GPIO   = TIO_ADDR_GPIO,
  parameter logic [5:0] ADDR_PWR    = TIO_ADDR_PWR,
  parameter logic [5:0] ADDR_STATUS = TIO_ADDR_STATUS
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [5:0]          reg_address,
  input  logic [15:0]         reg_bytecnt,
  input  logic [7:0]          reg_datai,
  output logic [7:0]          reg_datao,
  input  logic                reg_read,
  input  logic                reg_write,
  input  logic                reg_addrvalid,
  input  logic [5:0]          reg_hypaddress,
  output logic [15:0]         reg_hyplen,
  input  logic [CHANNELS-1:0] alt_a_i,
  input  logic [CHANNELS-1:0] alt_b_i,
  input  logic [CHANNELS-1:0] io_in,
  output logic [CHANNELS-1:0] io_in_sync,
  output logic [CHANNELS-1:0] io_out,
  output logic [CHANNELS-1:0] io_oe,
  output logic                target_npower
);

  localparam int GBYTES = tio_bytes(CHANNELS);
  localparam int GBITS  = GBYTES * 8;

  logic [GBITS-1:0]    gpio_q;
  logic                pwr_en_q;
  logic [15:0]         settle_q;
  logic [15:0]         cnt_q, cnt_d;
  tio_pwr_e            state_q, state_d;
  logic [CHANNELS-1:0] sync1_q, sync2_q;
  logic [GBITS-1:0]    sync_pad;
  logic [2:0]          mode_r [CHANNELS];
  logic                wr_en;

  assign wr_en    = reg_write & reg_addrvalid;
  assign sync_pad = GBITS'(sync2_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gpio_q   <= '0;
      pwr_en_q <= 1'b0;
      settle_q <= TIO_SETTLE_RESET;
    end else if (wr_en) begin
      if (reg_address == ADDR_GPIO) begin
        for (int b = 0; b < GBYTES; b++)
          if (reg_bytecnt == 16'(b)) gpio_q[b*8 +: 8] <= reg_datai;
      end
      if (reg_address == ADDR_PWR) begin
        if (reg_bytecnt == 16'd0) pwr_en_q       <= reg_datai[0];
        if (reg_bytecnt == 16'd1) settle_q[7:0]  <= reg_datai;
        if (reg_bytecnt == 16'd2) settle_q[15:8] <= reg_datai;
      end
    end
  end

  // The settle count is sampled only on entry to SETTLE, so later writes to it
  // cannot stretch or shorten a sequence already in progress.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      TIO_PWR_OFF: begin
        state_d = TIO_PWR_SETTLE;
        cnt_d   = settle_q;
      end
      TIO_PWR_SETTLE: begin
        if (cnt_q <= 16'd1) begin
          state_d = TIO_PWR_ON;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      TIO_PWR_ON: state_d = TIO_PWR_ON;
      default:    state_d = TIO_PWR_OFF;
    endcase
    if (!pwr_en_q) begin
      state_d = TIO_PWR_OFF;
      cnt_d   = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= TIO_PWR_OFF;
      cnt_q   <= 16'd0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync1_q <= io_in;
      sync2_q <= sync1_q;
    end
  end

  assign target_npower = (state_q == TIO_PWR_OFF);
  assign io_in_sync    = sync2_q;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
    tio_channel #(
      .BBM_CYCLES (BBM_CYCLES)
    ) u_chan (
      .clk          (clk),
      .reset_n      (reset_n),
      .mode_we_i    (wr_en && (reg_address == ADDR_MODE) && (reg_bytecnt == 16'(ch))),
      .mode_wdata_i (reg_datai[2:0]),
      .gpio_i       (gpio_q[ch]),
      .alt_a_i      (alt_a_i[ch]),
      .alt_b_i      (alt_b_i[ch]),
      .pwr_on_i     (state_q == TIO_PWR_ON),
      .mode_o       (mode_r[ch]),
      .io_out_o     (io_out[ch]),
      .io_oe_o      (io_oe[ch])
    );
  end

  always_comb begin
    reg_datao = 8'd0;
    if (reg_addrvalid && reg_read) begin
      case (reg_address)
        ADDR_MODE: begin
          for (int ch = 0; ch < CHANNELS; ch++)
            if (reg_bytecnt == 16'(ch)) reg_datao = {5'd0, mode_r[ch]};
        end
        ADDR_GPIO: begin
          for (int b = 0; b < GBYTES; b++)
            if (reg_bytecnt == 16'(b)) reg_datao = gpio_q[b*8 +: 8];
        end
        ADDR_PWR: begin
          if (reg_bytecnt == 16'd0) reg_datao = {7'd0, pwr_en_q};
          if (reg_bytecnt == 16'd1) reg_datao = settle_q[7:0];
          if (reg_bytecnt == 16'd2) reg_datao = settle_q[15:8];
        end
        ADDR_STATUS: begin
          for (int b = 0; b < GBYTES; b++)
            if (reg_bytecnt == 16'(b)) reg_datao = sync_pad[b*8 +: 8];
          if (reg_bytecnt == 16'(GBYTES)) reg_datao = {6'd0, state_q};
        end
        default: reg_datao = 8'd0;
      endcase
    end
  end

  always_comb begin
    reg_hyplen = 16'd0;
    case (reg_hypaddress)
      ADDR_MODE:   reg_hyplen = 16'(CHANNELS);
      ADDR_GPIO:   reg_hyplen = 16'(GBYTES);
      ADDR_PWR:    reg_hyplen = 16'd3;
      ADDR_STATUS: reg_hyplen = 16'(GBYTES + 1);
      default:     reg_hyplen = 16'd0;
    endcase
  end

endmodule

// File: tb/tb_target_io_router.sv
// Directed scoreboard bench for target_io_router (CHANNELS=8, BBM_CYCLES=2):
// power sequencing, mode blanking, OD/ALT muxing, input sync and register decode.
module tb_target_io_router;

  localparam logic [5:0] A_MODE = 6'd40;
  localparam logic [5:0] A_GPIO = 6'd41;
  localparam logic [5:0] A_PWR  = 6'd42;
  localparam logic [5:0] A_STAT = 6'd43;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  reg_address;
  logic [15:0] reg_bytecnt;
  logic [7:0]  reg_datai;
  logic [7:0]  reg_datao;
  logic        reg_read;
  logic        reg_write;
  logic        reg_addrvalid;
  logic [5:0]  reg_hypaddress;
  logic [15:0] reg_hyplen;
  logic [7:0]  alt_a_i;
  logic [7:0]  alt_b_i;
  logic [7:0]  io_in;
  logic [7:0]  io_in_sync;
  logic [7:0]  io_out;
  logic [7:0]  io_oe;
  logic        target_npower;

  int          testCount = 0;
  int          failCount = 0;
  string       tagQ[$];
  logic [31:0] expQ[$];
  logic [7:0]  rd;

  target_io_router dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .reg_address    (reg_address),
    .reg_bytecnt    (reg_bytecnt),
    .reg_datai      (reg_datai),
    .reg_datao      (reg_datao),
    .reg_read       (reg_read),
    .reg_write      (reg_write),
    .reg_addrvalid  (reg_addrvalid),
    .reg_hypaddress (reg_hypaddress),
    .reg_hyplen     (reg_hyplen),
    .alt_a_i        (alt_a_i),
    .alt_b_i        (alt_b_i),
    .io_in          (io_in),
    .io_in_sync     (io_in_sync),
    .io_out         (io_out),
    .io_oe          (io_oe),
    .target_npower  (target_npower)
  );

  always #10 clk = ~clk;

  task automatic expectVal(input string tag, input logic [31:0] v);
    tagQ.push_back(tag);
    expQ.push_back(v);
  endtask

  task automatic checkOutput(input logic [31:0] observed);
    string       tag;
    logic [31:0] expected;
    testCount++;
    if (expQ.size() == 0) begin
      failCount++;
      $error("[TB] FAIL scoreboard_empty observed=0x%0h expected=none", observed);
    end else begin
      tag      = tagQ.pop_front();
      expected = expQ.pop_front();
      assert (observed === expected) else begin
        failCount++;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    expectVal(tag, exp);
    checkOutput(obs);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [5:0] a, input logic [15:0] b, input logic [7:0] d);
    reg_address   = a;
    reg_bytecnt   = b;
    reg_datai     = d;
    reg_addrvalid = 1'b1;
    reg_write     = 1'b1;
    @(negedge clk);
    reg_write     = 1'b0;
    reg_addrvalid = 1'b0;
  endtask

  task automatic readReg(input logic [5:0] a, input logic [15:0] b, output logic [7:0] d);
    reg_address   = a;
    reg_bytecnt   = b;
    reg_addrvalid = 1'b1;
    reg_read      = 1'b1;
    #1;
    d             = reg_datao;
    reg_read      = 1'b0;
    reg_addrvalid = 1'b0;
  endtask

  task automatic hypLen(input logic [5:0] a, input logic [15:0] exp, input string tag);
    reg_hypaddress = a;
    #1;
    chk(tag, 32'(reg_hyplen), 32'(exp));
  endtask

  task automatic checkState(input logic [7:0] exp, input string tag);
    readReg(A_STAT, 16'd1, rd);
    chk(tag, 32'(rd), 32'(exp));
  endtask

  initial begin
    reset_n = 1'b0; reg_address = '0; reg_bytecnt = '0; reg_datai = '0;
    reg_read = 1'b0; reg_write = 1'b0; reg_addrvalid = 1'b0; reg_hypaddress = '0;
    alt_a_i = '0; alt_b_i = '0; io_in = '0;
    tick(); tick();
    chk("rst_oe", 32'(io_oe), 32'h00);
    chk("rst_out", 32'(io_out), 32'h00);
    chk("rst_npower", 32'(target_npower), 32'h1);
    chk("rst_sync", 32'(io_in_sync), 32'h00);
    chk("rst_datao", 32'(reg_datao), 32'h00);
    reset_n = 1'b1;
    tick();
    checkState(8'h00, "rst_state");
    readReg(A_PWR, 16'd1, rd); chk("rst_settle_lo", 32'(rd), 32'hE8);
    readReg(A_PWR, 16'd2, rd); chk("rst_settle_hi", 32'(rd), 32'h03);
    tick();
    hypLen(A_MODE, 16'd8, "hyplen_mode");
    hypLen(A_GPIO, 16'd1, "hyplen_gpio");
    hypLen(A_PWR,  16'd3, "hyplen_pwr");
    hypLen(A_STAT, 16'd2, "hyplen_status");
    tick();

    // Power-up with settle=5: five SETTLE cycles then ON.
    applyStimulus(A_PWR, 16'd1, 8'd5);
    applyStimulus(A_PWR, 16'd2, 8'd0);
    applyStimulus(A_PWR, 16'd0, 8'd1);
    chk("pwr_npower_before", 32'(target_npower), 32'h1);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("settle_npower_%0d", i), 32'(target_npower), 32'h0);
      chk($sformatf("settle_oe_%0d", i), 32'(io_oe), 32'h00);
      checkState(8'h01, $sformatf("settle_state_%0d", i));
      tick();
    end
    checkState(8'h02, "pwr_on_state");

    // Channel 3 GPIO: blanked two cycles beyond the normal output latency.
    applyStimulus(A_GPIO, 16'd0, 8'h08);
    applyStimulus(A_MODE, 16'd3, 8'h01);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bbm3_oe_%0d", i), 32'(io_oe[3]), 32'h0);
      tick();
    end
    chk("gpio3_oe", 32'(io_oe[3]), 32'h1);
    chk("gpio3_out", 32'(io_out[3]), 32'h1);
    applyStimulus(A_MODE, 16'd3, 8'hF9);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("same_mode_oe_%0d", i), 32'(io_oe[3]), 32'h1);
      tick();
    end
    readReg(A_MODE, 16'd3, rd); chk("mode3_readback", 32'(rd), 32'h01);

    // Channel 0 open-drain, channel 1 ALT_A, channel 2 ALT_B, channel 4 reserved mode.
    applyStimulus(A_MODE, 16'd0, 8'h02);
    tick(); tick(); tick();
    chk("od_oe_low_gpio", 32'(io_oe), 32'h09);
    applyStimulus(A_GPIO, 16'd0, 8'h09);
    chk("od_oe_lag", 32'(io_oe[0]), 32'h1);
    tick();
    chk("od_oe_release", 32'(io_oe), 32'h08);
    chk("od_out", 32'(io_out[0]), 32'h0);
    applyStimulus(A_MODE, 16'd1, 8'h03);
    tick(); tick(); tick();
    chk("alta_oe", 32'(io_oe), 32'h0A);
    alt_a_i = 8'h02;
    #1;
    chk("alta_lag", 32'(io_out[1]), 32'h0);
    tick();
    chk("alta_follow_hi", 32'(io_out[1]), 32'h1);
    alt_a_i = 8'h00;
    tick();
    chk("alta_follow_lo", 32'(io_out[1]), 32'h0);
    applyStimulus(A_MODE, 16'd2, 8'h04);
    applyStimulus(A_MODE, 16'd4, 8'h05);
    alt_b_i = 8'h04;
    tick(); tick(); tick();
    chk("altb_oe", 32'(io_oe), 32'h0E);
    chk("altb_out", 32'(io_out), 32'h0C);
    readReg(A_MODE, 16'd4, rd); chk("mode4_readback", 32'(rd), 32'h05);
    readReg(A_MODE, 16'd8, rd); chk("mode_oob_read", 32'(rd), 32'h00);

    // Power off, then abort a SETTLE with three cycles remaining.
    applyStimulus(A_PWR, 16'd0, 8'd0);
    checkState(8'h02, "off_req_state");
    tick();
    checkState(8'h00, "off_state");
    chk("off_npower", 32'(target_npower), 32'h1);
    chk("off_oe_lag", 32'(io_oe), 32'h0E);
    tick();
    chk("off_oe", 32'(io_oe), 32'h00);
    applyStimulus(A_PWR, 16'd1, 8'd10);
    applyStimulus(A_PWR, 16'd2, 8'd0);
    applyStimulus(A_PWR, 16'd0, 8'd1);
    checkState(8'h00, "abort_pre");
    applyStimulus(A_PWR, 16'd1, 8'd2);
    for (int i = 0; i < 7; i++) begin
      checkState(8'h01, $sformatf("abort_settle_%0d", i));
      chk($sformatf("abort_settle_oe_%0d", i), 32'(io_oe), 32'h00);
      tick();
    end
    checkState(8'h01, "abort_left3");
    applyStimulus(A_PWR, 16'd0, 8'd0);
    checkState(8'h01, "abort_req");
    tick();
    for (int i = 0; i < 5; i++) begin
      checkState(8'h00, $sformatf("abort_off_%0d", i));
      chk($sformatf("abort_npower_%0d", i), 32'(target_npower), 32'h1);
      chk($sformatf("abort_oe_%0d", i), 32'(io_oe), 32'h00);
      tick();
    end

    // Zero settle count: ON the cycle after entering SETTLE.
    applyStimulus(A_PWR, 16'd1, 8'd0);
    applyStimulus(A_PWR, 16'd0, 8'd1);
    checkState(8'h00, "s0_off");
    tick();
    checkState(8'h01, "s0_settle");
    tick();
    checkState(8'h02, "s0_on");
    tick();
    chk("s0_oe", 32'(io_oe), 32'h0E);

    // Input synchroniser and unowned addresses.
    io_in = 8'h20;
    tick();
    chk("sync_lag", 32'(io_in_sync[5]), 32'h0);
    tick();
    chk("sync_follow", 32'(io_in_sync[5]), 32'h1);
    readReg(A_STAT, 16'd0, rd); chk("status_sync", 32'(rd), 32'h20);
    readReg(6'd20, 16'd0, rd); chk("unowned_read", 32'(rd), 32'h00);
    hypLen(6'd20, 16'd0, "unowned_hyplen");
    reg_address = A_MODE; reg_bytecnt = 16'd3; reg_addrvalid = 1'b1; reg_read = 1'b0;
    #1;
    chk("no_read_strobe", 32'(reg_datao), 32'h00);
    reg_addrvalid = 1'b0;
    tick();

    // Reset while powered drops everything immediately.
    reset_n = 1'b0;
    #1;
    chk("midrst_npower", 32'(target_npower), 32'h1);
    chk("midrst_oe", 32'(io_oe), 32'h00);
    chk("midrst_out", 32'(io_out), 32'h00);
    chk("midrst_sync", 32'(io_in_sync), 32'h00);
    checkState(8'h00, "midrst_state");
    tick();
    reset_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
